// File: rtl/traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Multi-phase intersection controller. It sequences NUM_PHASES mutually
// exclusive signal phases through GREEN -> YELLOW -> ALL_RED -> GREEN.
// The next phase is chosen by round-robin over the per-phase requests.
// Green is held while the active phase keeps requesting, bounded by
// GREEN_MAX. An emergency pre-emption input can force a chosen phase green.
//
// All outputs decode registered state (Moore). No input reaches an output
// combinationally.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   req            in   level request per phase
//   preempt_valid  in   emergency pre-emption active (level)
//   preempt_phase  in   phase to force green; ignored if >= NUM_PHASES
//   green          out  one-hot green lamp, zero outside GREEN
//   yellow         out  one-hot yellow lamp, zero outside YELLOW
//   all_red        out  high in ALL_RED
//   cur_phase      out  phase last or currently granted
//   grant_pulse    out  high on the first cycle of every GREEN
//   state_dbg      out  raw FSM state (0=ALL_RED, 1=GREEN, 2=YELLOW)
//
// Handshake: there is none. req and preempt_valid are levels. They are
// sampled only when the FSM makes a decision: on every GREEN cycle and on
// the last ALL_RED cycle. A request that rises and falls between decisions
// is not remembered.
// ---------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2,
    parameter int TIMER_W    = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_T   = 3,
    parameter int RED_T      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  preempt_valid,
    input  logic [PHASE_W-1:0]    preempt_phase,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic                  all_red,
    output logic [PHASE_W-1:0]    cur_phase,
    output logic                  grant_pulse,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_e;

    // Reload values and green thresholds, pre-sized to the counter width.
    localparam logic [TIMER_W-1:0] RED_LOAD    = TIMER_W'(RED_T - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] GMIN_LAST   = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_LAST   = TIMER_W'(GREEN_MAX - 1);

    // One extra bit so that NUM_PHASES itself is representable; otherwise
    // NUM_PHASES == 2**PHASE_W would wrap to zero.
    localparam logic [PHASE_W:0]   NUM_PH_EXT  = (PHASE_W + 1)'(NUM_PHASES);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e               state_q,     state_d;
    logic [TIMER_W-1:0]   timer_q,     timer_d;
    logic [TIMER_W-1:0]   green_cnt_q, green_cnt_d;
    logic [PHASE_W-1:0]   cur_phase_q, cur_phase_d;
    logic                 grant_q,     grant_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [NUM_PHASES-1:0] cur_onehot;
    logic [NUM_PHASES-1:0] others;
    logic                  own_req;
    logic                  valid_pre;
    logic                  pre_is_cur;
    logic [PHASE_W-1:0]    rr_phase;
    logic                  rr_any;
    int                    rr_best;
    int                    rr_dist;

    always_comb begin
        cur_onehot = '0;
        for (int j = 0; j < NUM_PHASES; j++) begin
            cur_onehot[j] = (cur_phase_q == PHASE_W'(j));
        end
    end

    assign others     = req & ~cur_onehot;
    assign own_req    = |(req & cur_onehot);
    assign valid_pre  = preempt_valid && ({1'b0, preempt_phase} < NUM_PH_EXT);
    assign pre_is_cur = (preempt_phase == cur_phase_q);
    assign rr_any     = |req;

    // Round-robin pick. Each requesting phase j gets a distance from the
    // current phase of 1..NUM_PHASES, with the current phase itself at
    // NUM_PHASES, so it is checked last. The smallest distance wins. Doing
    // it this way keeps every req[] index a loop constant.
    always_comb begin
        rr_phase = cur_phase_q;
        rr_best  = NUM_PHASES + 1;
        rr_dist  = 0;
        for (int j = 0; j < NUM_PHASES; j++) begin
            rr_dist = j - int'(cur_phase_q);
            if (rr_dist <= 0) begin
                rr_dist = rr_dist + NUM_PHASES;
            end
            if (req[j] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_phase = PHASE_W'(j);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ALL_RED;
            timer_q     <= RED_LOAD;
            green_cnt_q <= '0;
            cur_phase_q <= '0;
            grant_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            green_cnt_q <= green_cnt_d;
            cur_phase_q <= cur_phase_d;
            grant_q     <= grant_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        green_cnt_d = green_cnt_q;
        cur_phase_d = cur_phase_q;
        grant_d     = 1'b0;

        unique case (state_q)
            ST_ALL_RED: begin
                if (timer_q == '0) begin
                    state_d     = ST_GREEN;
                    green_cnt_d = '0;
                    grant_d     = 1'b1;
                    // Pre-emption beats round-robin. With no request at
                    // all, rest in the last green.
                    if (valid_pre) begin
                        cur_phase_d = preempt_phase;
                    end else if (rr_any) begin
                        cur_phase_d = rr_phase;
                    end else begin
                        cur_phase_d = cur_phase_q;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_GREEN: begin
                if (valid_pre && !pre_is_cur) begin
                    // An emergency for another phase ignores the minimum green.
                    state_d = ST_YELLOW;
                    timer_d = YELLOW_LOAD;
                end else if (valid_pre && pre_is_cur) begin
                    // Pre-empted phase holds green and the counter is frozen;
                    // the green limits do not apply while the emergency lasts.
                    state_d = ST_GREEN;
                end else if ((others != '0) && (green_cnt_q >= GMIN_LAST) &&
                             (!own_req || (green_cnt_q == GMAX_LAST))) begin
                    state_d = ST_YELLOW;
                    timer_d = YELLOW_LOAD;
                end else begin
                    if (green_cnt_q != GMAX_LAST) begin
                        green_cnt_d = green_cnt_q + 1'b1;
                    end
                end
            end

            ST_YELLOW: begin
                // Yellow is never cut short, not even by pre-emption.
                if (timer_q == '0) begin
                    state_d = ST_ALL_RED;
                    timer_d = RED_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_ALL_RED;
                timer_d = RED_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign green       = (state_q == ST_GREEN)  ? cur_onehot : '0;
    assign yellow      = (state_q == ST_YELLOW) ? cur_onehot : '0;
    assign all_red     = (state_q == ST_ALL_RED);
    assign cur_phase   = cur_phase_q;
    assign grant_pulse = grant_q;
    assign state_dbg   = state_q;

    // ------------------------------------------------------------------
    // Lamp safety invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_lamp_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(green | yellow));
    a_all_red_excl : assert property (@(posedge clk) disable iff (rst)
        all_red == ((green | yellow) == '0));
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Directed, table-driven bench for traffic_phase_ctrl with the default
// parameters (4 phases, green 4..8, yellow 3, all-red 2). Each table row
// holds the inputs, a repeat count and the outputs expected after every
// clock edge of that row. Hand-written sequences at the end cover request
// pulses and pre-emption through yellow/all-red.
// ---------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int OW = 2 * NP + 1 + PW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req;
  logic          preempt_valid;
  logic [PW-1:0] preempt_phase;
  logic [NP-1:0] green;
  logic [NP-1:0] yellow;
  logic          all_red;
  logic [PW-1:0] cur_phase;
  logic          grant_pulse;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .preempt_valid (preempt_valid),
    .preempt_phase (preempt_phase),
    .green         (green),
    .yellow        (yellow),
    .all_red       (all_red),
    .cur_phase     (cur_phase),
    .grant_pulse   (grant_pulse),
    .state_dbg     (state_dbg)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    logic          pv;
    logic [PW-1:0] pp;
    int            n;
    logic [NP-1:0] g;
    logic [NP-1:0] y;
    logic          ar;
    logic [PW-1:0] cur;
    logic          gp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [NP-1:0] rq,
                              input logic pv, input logic [PW-1:0] pp,
                              input int n, input logic [NP-1:0] g,
                              input logic [NP-1:0] y, input logic ar,
                              input logic [PW-1:0] cur, input logic gp);
    vec_t v;
    v.rst = r; v.req = rq; v.pv = pv; v.pp = pp; v.n = n;
    v.g = g; v.y = y; v.ar = ar; v.cur = cur; v.gp = gp;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [NP-1:0] rq,
                       input logic pv, input logic [PW-1:0] pp);
    rst           = r;
    req           = rq;
    preempt_valid = pv;
    preempt_phase = pp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string name);
    logic [OW-1:0] exp_v;
    logic [OW-1:0] got_v;
    exp_v = exp_q.pop_front();
    got_v = {green, yellow, all_red, cur_phase, grant_pulse};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got{g,y,ar,cur,gp}=%b_%b_%b_%0d_%b required=%b_%b_%b_%0d_%b",
               name, $time,
               got_v[OW-1 -: NP], got_v[OW-NP-1 -: NP], got_v[PW+1], got_v[PW:1], got_v[0],
               exp_v[OW-1 -: NP], exp_v[OW-NP-1 -: NP], exp_v[PW+1], exp_v[PW:1], exp_v[0]);
    end
    checks++;
    if (!$onehot0(green | yellow)) begin
      failures++;
      $display("FAIL %s_lamp_onehot t=%0t got green|yellow=%b required at most one bit",
               name, $time, green | yellow);
    end
    checks++;
    if (all_red !== ((green | yellow) == '0)) begin
      failures++;
      $display("FAIL %s_all_red t=%0t got all_red=%b required %b",
               name, $time, all_red, ((green | yellow) == '0));
    end
  endtask

  task automatic check_out(input string name, input logic [NP-1:0] g,
                           input logic [NP-1:0] y, input logic ar,
                           input logic [PW-1:0] cur, input logic gp);
    exp_q.push_back({g, y, ar, cur, gp});
    compare_out(name);
  endtask

  // Steps one edge at a time until grant_pulse, at most max_cycles edges.
  task automatic wait_grant(input string name, input int max_cycles, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (grant_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout got no grant_pulse required one within %0d cycles",
               name, max_cycles);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ok;
    drive(1'b1, '0, 1'b0, '0);

    // Reset with no requests: 2 all-red cycles, then rest on phase 0.
    add(1, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h1, 4'h0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 50, 4'h1, 4'h0, 0, 0, 0);
    // Fresh phase 0 green; req=0010 from green_cnt=0 -> minimum green.
    add(1, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h1, 4'h0, 0, 0, 1);
    add(0, 4'h2, 0, 0, 3,  4'h1, 4'h0, 0, 0, 0);
    add(0, 4'h2, 0, 0, 3,  4'h0, 4'h1, 0, 0, 0);
    add(0, 4'h2, 0, 0, 2,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h2, 0, 0, 1,  4'h2, 4'h0, 0, 1, 1);
    // Phase 1 green, req=1001 -> phase 3, which holds to max, then wraps to 0.
    add(0, 4'h9, 0, 0, 3,  4'h2, 4'h0, 0, 1, 0);
    add(0, 4'h9, 0, 0, 3,  4'h0, 4'h2, 0, 1, 0);
    add(0, 4'h9, 0, 0, 2,  4'h0, 4'h0, 1, 1, 0);
    add(0, 4'h9, 0, 0, 1,  4'h8, 4'h0, 0, 3, 1);
    add(0, 4'h9, 0, 0, 7,  4'h8, 4'h0, 0, 3, 0);
    add(0, 4'h9, 0, 0, 3,  4'h0, 4'h8, 0, 3, 0);
    add(0, 4'h9, 0, 0, 2,  4'h0, 4'h0, 1, 3, 0);
    add(0, 4'h9, 0, 0, 1,  4'h1, 4'h0, 0, 0, 1);
    // Phase 0 green, req=0011 held -> 8 green cycles, then phase 1.
    add(0, 4'h3, 0, 0, 7,  4'h1, 4'h0, 0, 0, 0);
    add(0, 4'h3, 0, 0, 3,  4'h0, 4'h1, 0, 0, 0);
    add(0, 4'h3, 0, 0, 2,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h3, 0, 0, 1,  4'h2, 4'h0, 0, 1, 1);
    // req=0100 from reset -> phase 2 green, held indefinitely.
    add(1, 4'h4, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h4, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h4, 0, 0, 1,  4'h4, 4'h0, 0, 2, 1);
    add(0, 4'h4, 0, 0, 40, 4'h4, 4'h0, 0, 2, 0);
    // Pre-emption to phase 2 at green cycle 1; reset in the middle of yellow.
    add(1, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h1, 4'h0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 1,  4'h1, 4'h0, 0, 0, 0);
    add(0, 4'hA, 1, 2, 3,  4'h0, 4'h1, 0, 0, 0);
    add(0, 4'hA, 1, 2, 2,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'hA, 1, 2, 1,  4'h4, 4'h0, 0, 2, 1);
    add(0, 4'hA, 1, 2, 20, 4'h4, 4'h0, 0, 2, 0);
    add(0, 4'hA, 1, 3, 1,  4'h0, 4'h4, 0, 2, 0);
    add(1, 4'hA, 1, 3, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h0, 4'h0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1,  4'h1, 4'h0, 0, 0, 1);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].pv, vecs[k].pp);
      for (int c = 0; c < vecs[k].n; c++) begin
        exp_q.push_back({vecs[k].g, vecs[k].y, vecs[k].ar, vecs[k].cur, vecs[k].gp});
        tick();
        compare_out($sformatf("vec%0d_c%0d", k, c));
      end
    end

    // A one-cycle request pulse ends phase 0 green. The pulse is gone by
    // the all-red exit, so the controller rests on phase 0 again.
    drive(1'b0, 4'h0, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      tick(); check_out("pulse_hold", 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    end
    drive(1'b0, 4'h2, 1'b0, '0);
    tick(); check_out("pulse_yellow", 4'h0, 4'h1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, '0);
    for (int c = 0; c < 2; c++) begin
      tick(); check_out("pulse_yellow_rest", 4'h0, 4'h1, 1'b0, 2'd0, 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      tick(); check_out("pulse_all_red", 4'h0, 4'h0, 1'b1, 2'd0, 1'b0);
    end
    tick(); check_out("pulse_not_latched", 4'h1, 4'h0, 1'b0, 2'd0, 1'b1);

    // Pre-emption raised during yellow: yellow runs its full length, and
    // the all-red exit takes the pre-empt phase over the round-robin pick.
    drive(1'b0, 4'h8, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      tick(); check_out("rr_min_green", 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
    end
    tick(); check_out("rr_yellow", 4'h0, 4'h1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'h8, 1'b1, 2'd2);
    for (int c = 0; c < 2; c++) begin
      tick(); check_out("pre_yellow_full", 4'h0, 4'h1, 1'b0, 2'd0, 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      tick(); check_out("pre_all_red", 4'h0, 4'h0, 1'b1, 2'd0, 1'b0);
    end
    tick(); check_out("pre_beats_rr", 4'h4, 4'h0, 1'b0, 2'd2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick(); check_out("pre_hold", 4'h4, 4'h0, 1'b0, 2'd2, 1'b0);
    end

    // Pre-emption released: phase 3 still waits and must be served.
    drive(1'b0, 4'h8, 1'b0, '0);
    wait_grant("release_grant", 40, ok);
    if (ok) begin
      check_out("release_phase3", 4'h8, 4'h0, 1'b0, 2'd3, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout got no end of test required finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
